// File: rtl/axis_i2s_rx_fifo.sv
// I2S master receiver: generates bclk/lrclk, deserialises stereo samples and
// queues sign-extended words in a FIFO drained over AXI4-Stream.
module axis_i2s_rx_fifo #(
    parameter int DATA_W     = 24,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic             m_axis_aclk,
    input  logic             m_axis_arstn,
    input  logic             enable,
    output logic             bclk,
    output logic             lrclk,
    input  logic             sda,
    input  logic             m_axis_tready,
    output logic             m_axis_tvalid,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    // A slot only carries bits 1..31, so a 32-bit word completes at slot 31.
    localparam int CAP_W = (DATA_W > 31) ? 31 : DATA_W;
    localparam logic [4:0] S_LAST = 5'(CAP_W);
    localparam int AW = LVL_W - 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic                bclk_q;
    logic [5:0]          slot_q;
    logic [DATA_W-1:0]   shift_q;
    logic                done_q;
    logic [LVL_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic                ovf_q;
    logic [32:0]         mem_q [FIFO_DEPTH];

    logic [4:0]          s;
    logic [LVL_W-1:0]    level;
    logic                valid, full, pop, wr_en, drop, ovf_d;
    logic [32:0]         push_word, rd_word;

    assign s = slot_q[4:0];

    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            state_q <= IDLE;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q   <= '0;
                    bclk_q  <= 1'b0;
                    slot_q  <= '0;
                    shift_q <= '0;
                    if (enable) state_q <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        div_q   <= '0;
                        bclk_q  <= 1'b0;
                        slot_q  <= '0;
                        shift_q <= '0;
                    end else if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        bclk_q <= ~bclk_q;
                        if (bclk_q) begin
                            slot_q <= slot_q + 6'd1;
                        end else if (s != 5'd0 && s <= S_LAST) begin
                            shift_q <= {shift_q[DATA_W-2:0], sda};
                            done_q  <= (s == S_LAST);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The word is pushed one cycle after capture; lrclk cannot change in between.
    assign push_word = {slot_q[5], 32'($signed(shift_q))};

    always_comb begin
        level = wr_ptr_q - rd_ptr_q;
        valid = (level != '0);
        full  = (level == LVL_W'(FIFO_DEPTH));
        pop   = valid & m_axis_tready;
        wr_en = done_q & (~full | pop);
        drop  = done_q & full & ~pop;
        ovf_d = drop | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + LVL_W'(1);
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

    assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = valid;
    assign m_axis_tdata  = valid ? rd_word[31:0] : '0;
    assign m_axis_tuser  = valid & rd_word[32];
    assign m_axis_tlast  = valid & rd_word[32];
    assign overflow      = ovf_q;
    assign fifo_level    = level;
    assign bclk          = bclk_q;
    assign lrclk         = slot_q[5];

endmodule

// File: tb/tb_axis_i2s_rx_fifo.sv
// Bench for axis_i2s_rx_fifo: an I2S transmitter model follows bclk and a
// queue-based FIFO model predicts every AXIS output cycle by cycle.
module tb_axis_i2s_rx_fifo;
    localparam int DATA_W     = 24;
    localparam int BCLK_DIV   = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int LVL_W      = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enable, sda, tready, clr;
    logic              bclk, lrclk, tvalid, tuser, tlast, overflow;
    logic [31:0]       tdata;
    logic [LVL_W-1:0]  level;

    axis_i2s_rx_fifo #(
        .DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
    ) dut (
        .m_axis_aclk(clk), .m_axis_arstn(rstn), .enable(enable), .bclk(bclk),
        .lrclk(lrclk), .sda(sda), .m_axis_tready(tready), .m_axis_tvalid(tvalid),
        .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .overflow(overflow), .clr_overflow(clr), .fifo_level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] l_in;
        logic [31:0] r_in;
        logic [31:0] l_exp;
        logic [31:0] r_exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } word_t;

    vec_t        tbl [4];
    word_t       q[$];
    word_t       seen[$];
    word_t       pend_w, last_obs, w;
    bit          pend, m_ovf, bprev, rise_ok, tbl_mode;
    int          slot, since_rise, tbl_idx, budget;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_word [2];
    logic [31:0] exp_word [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v);
        logic [31:0] mask;
        mask = (32'd1 << DATA_W) - 32'd1;
        return v[DATA_W-1] ? ((v & mask) | ~mask) : (v & mask);
    endfunction

    task automatic load_word(input int ch);
        if (tbl_mode) begin
            cur_word[ch] = (ch == 1) ? tbl[tbl_idx].r_in  : tbl[tbl_idx].l_in;
            exp_word[ch] = (ch == 1) ? tbl[tbl_idx].r_exp : tbl[tbl_idx].l_exp;
            if (ch == 1) begin
                tbl_idx++;
                if (tbl_idx == 4) tbl_mode = 1'b0;
            end
        end else begin
            cur_word[ch] = $urandom;
            exp_word[ch] = sext(cur_word[ch]);
        end
    endtask

    // One aclk cycle: account for the edge just passed, compare, then drive sda.
    task automatic tick();
        logic en, rdy, clr_v;
        bit   pop, full, drop;
        int   s;
        @(negedge clk);
        en = enable; rdy = tready; clr_v = clr;
        pop  = (q.size() > 0) && rdy;
        full = (q.size() == FIFO_DEPTH);
        if (pop) begin
            w = q.pop_front();
            seen.push_back(last_obs);
        end
        drop = 1'b0;
        if (pend) begin
            if (full && !pop) drop = 1'b1;
            else q.push_back(pend_w);
            pend = 1'b0;
        end
        m_ovf = drop || (m_ovf && !clr_v);

        chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata", tdata, q[0].data);
            chk("tuser", 32'(tuser), 32'(q[0].user));
            chk("tlast", 32'(tlast), 32'(q[0].last));
        end
        chk("fifo_level", 32'(level), q.size());
        chk("overflow", 32'(overflow), 32'(m_ovf));
        last_obs = '{tdata, tuser, tlast};

        if (!en) begin
            chk("bclk_idle", 32'(bclk), 32'd0);
            chk("lrclk_idle", 32'(lrclk), 32'd0);
            slot = 0; rise_ok = 1'b0; since_rise = 0;
        end else begin
            since_rise++;
            s = slot % 32;
            if (bclk && !bprev) begin
                if (rise_ok) chk("bclk_period", since_rise, 2 * BCLK_DIV);
                rise_ok = 1'b1; since_rise = 0;
                if (s == DATA_W) begin
                    pend   = 1'b1;
                    pend_w = '{exp_word[slot / 32], 1'(slot / 32), 1'(slot / 32)};
                end
            end else if (!bclk && bprev) begin
                slot = (slot + 1) % 64;
                if (slot % 32 == 1) load_word(slot / 32);
            end
            chk("lrclk", 32'(lrclk), slot / 32);
        end
        bprev = bclk;
        s = slot % 32;
        sda = (s >= 1 && s <= DATA_W) ? cur_word[slot / 32][DATA_W - s] : 1'($urandom);
    endtask

    task automatic model_reset();
        q.delete(); seen.delete();
        pend = 1'b0; m_ovf = 1'b0; bprev = 1'b0; rise_ok = 1'b0;
        slot = 0; since_rise = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{32'h00123456, 32'h00ABCDEF, 32'h00123456, 32'hFFABCDEF};
        tbl[1] = '{32'h00800000, 32'h007FFFFF, 32'hFF800000, 32'h007FFFFF};
        tbl[2] = '{32'h00000000, 32'h00FFFFFF, 32'h00000000, 32'hFFFFFFFF};
        tbl[3] = '{32'hFF000001, 32'h00800001, 32'h00000001, 32'hFF800001};
        tbl_mode = 1'b0; tbl_idx = 0;
        cur_word[0] = '0; cur_word[1] = '0; exp_word[0] = '0; exp_word[1] = '0;
        model_reset();
        enable = 1'b0; sda = 1'b0; tready = 1'b0; clr = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_lrclk", 32'(lrclk), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Table-driven stereo pairs with tready held high
        tbl_mode = 1'b1; tready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            budget = 2000;
            while (seen.size() < 2 && budget > 0) begin tick(); budget--; end
            if (seen.size() < 2) begin
                chk("table_timeout", seen.size(), 2);
            end else begin
                w = seen.pop_front();
                chk("tbl_left_data", w.data, tbl[i].l_exp);
                chk("tbl_left_user", 32'(w.user), 32'd0);
                chk("tbl_left_last", 32'(w.last), 32'd0);
                w = seen.pop_front();
                chk("tbl_right_data", w.data, tbl[i].r_exp);
                chk("tbl_right_user", 32'(w.user), 32'd1);
                chk("tbl_right_last", 32'(w.last), 32'd1);
            end
        end

        // Random samples with random backpressure
        repeat (6 * 256) begin tick(); tready = 1'($urandom); end

        // Backpressure: 5 frames with tready low
        enable = 1'b0; tready = 1'b1;
        repeat (40) tick();
        clr = 1'b1; tick(); clr = 1'b0; tick();
        seen.delete();
        tready = 1'b0; enable = 1'b1;
        repeat (5 * 256) tick();
        chk("bp_level", 32'(level), 32'd8);
        chk("bp_overflow", 32'(overflow), 32'd1);
        enable = 1'b0; tready = 1'b1;
        repeat (20) tick();
        chk("bp_drained", seen.size(), 8);
        for (int k = 0; k < 8 && k < seen.size(); k++) begin
            chk("bp_order_user", 32'(seen[k].user), 32'(k % 2));
            chk("bp_order_last", 32'(seen[k].last), 32'(k % 2));
        end

        // Clear race: clean clear on a full FIFO, then clear colliding with a drop
        seen.delete(); tready = 1'b0; enable = 1'b1;
        budget = 3000;
        while (!(q.size() == FIFO_DEPTH && !pend) && budget > 0) begin tick(); budget--; end
        chk("fill_level", 32'(level), 32'd8);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_clean", 32'(overflow), 32'd0);
        budget = 600;
        while (!pend && budget > 0) begin tick(); budget--; end
        chk("race_pending", 32'(pend), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_race", 32'(overflow), 32'd1);
        tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_later", 32'(overflow), 32'd0);

        // Push and pop together while full
        budget = 600;
        while (!pend && budget > 0) begin tick(); budget--; end
        chk("pushpop_pending", 32'(pend), 32'd1);
        tready = 1'b1; tick(); tready = 1'b0;
        chk("pushpop_level", 32'(level), 32'd8);
        chk("pushpop_ovf", 32'(overflow), 32'd0);

        // Enable dropped at slot 10 of a left word
        enable = 1'b0; tready = 1'b1;
        repeat (30) tick();
        seen.delete(); enable = 1'b1;
        budget = 400;
        while (slot != 10 && budget > 0) begin tick(); budget--; end
        chk("en_slot10", slot, 10);
        enable = 1'b0; tick();
        chk("en_off_bclk", 32'(bclk), 32'd0);
        chk("en_off_lrclk", 32'(lrclk), 32'd0);
        repeat (300) tick();
        chk("en_off_no_push", seen.size(), 0);
        chk("en_off_level", 32'(level), 32'd0);
        enable = 1'b1;
        budget = 600;
        while (seen.size() < 1 && budget > 0) begin tick(); budget--; end
        chk("reenable_word", seen.size(), 1);
        if (seen.size() > 0) chk("reenable_left", 32'(seen[0].user), 32'd0);

        // Asynchronous reset mid-stream
        tready = 1'b0;
        budget = 2000;
        while (q.size() != 5 && budget > 0) begin tick(); budget--; end
        chk("pre_reset_level", 32'(level), 32'd5);
        chk("pre_reset_tvalid", 32'(tvalid), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_tdata", tdata, 32'd0);
        chk("mid_rst_tuser", 32'(tuser), 32'd0);
        chk("mid_rst_tlast", 32'(tlast), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_bclk", 32'(bclk), 32'd0);
        chk("mid_rst_lrclk", 32'(lrclk), 32'd0);
        model_reset();
        enable = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
